// File: rtl/mem_lsu_if.sv
// mem_lsu_pkg / mem_lsu_if
//
// Purpose: opcode encodings shared by the load/store unit and its bench, and
// the data-bus interface between the MEM-stage LSU and the data memory.
//
// Interface mem_lsu_if signals:
//   bus_req    LSU -> mem   access request (held until bus_ack)
//   bus_we     LSU -> mem   1 = store
//   bus_addr   LSU -> mem   word-aligned address
//   bus_sel    LSU -> mem   byte lanes, bit3 = bits[31:24] (big-endian)
//   bus_wdata  LSU -> mem   lane-replicated store data
//   bus_rdata  mem -> LSU   read data, valid with bus_ack
//   bus_ack    mem -> LSU   one-cycle completion pulse
// Modports: master (LSU side), slave (memory side).

package mem_lsu_pkg;
    localparam int ALUOP_W = 8;

    localparam logic [ALUOP_W-1:0] ALU_ADD_OP = 8'h10;
    localparam logic [ALUOP_W-1:0] ALU_LB_OP  = 8'h20;
    localparam logic [ALUOP_W-1:0] ALU_LH_OP  = 8'h21;
    localparam logic [ALUOP_W-1:0] ALU_LW_OP  = 8'h23;
    localparam logic [ALUOP_W-1:0] ALU_LBU_OP = 8'h24;
    localparam logic [ALUOP_W-1:0] ALU_LHU_OP = 8'h25;
    localparam logic [ALUOP_W-1:0] ALU_SB_OP  = 8'h28;
    localparam logic [ALUOP_W-1:0] ALU_SH_OP  = 8'h29;
    localparam logic [ALUOP_W-1:0] ALU_SW_OP  = 8'h2B;
endpackage

interface mem_lsu_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/mem_lsu.sv
// mem_lsu
//
// Purpose: MEM-stage load/store unit. Loads and stores run a req/ack
// transaction on the data bus while stallreq holds the pipeline; load data is
// lane-extracted and sign/zero-extended, store data is lane-replicated.
// Non-memory instructions pass straight through to MEM/WB combinationally.
//
// Ports:
//   clk, rst (async, active-low)
//   stall_mem        MEM/WB register held this cycle
//   flush            discard the in-flight MEM instruction
//   mem_aluop, mem_mem_addr, mem_reg2_data, mem_alu_res, mem_waddr, mem_reg_we
//                    EX/MEM register fields
//   wb_waddr, wb_reg_we, wb_wdata   result towards MEM/WB
//   stallreq         stall request to the pipeline controller
//   adel, ades       misaligned load / store
//   bus              data-bus master port (mem_lsu_if.master)

module mem_lsu
    import mem_lsu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_mem,
    input  logic               flush,
    input  logic [ALUOP_W-1:0] mem_aluop,
    input  logic [31:0]        mem_mem_addr,
    input  logic [31:0]        mem_reg2_data,
    input  logic [31:0]        mem_alu_res,
    input  logic [4:0]         mem_waddr,
    input  logic               mem_reg_we,
    output logic [4:0]         wb_waddr,
    output logic               wb_reg_we,
    output logic [31:0]        wb_wdata,
    output logic               stallreq,
    output logic               adel,
    output logic               ades,
    mem_lsu_if.master          bus
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // Big-endian lane enables: byte 0 of the word lives in bits[31:24].
    function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SZ_B:    lane_sel = 4'b1000 >> a;
            SZ_H:    lane_sel = a[1] ? 4'b0011 : 4'b1100;
            default: lane_sel = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] d);
        case (size)
            SZ_B:    store_data = {4{d[7:0]}};
            SZ_H:    store_data = {2{d[15:0]}};
            default: store_data = d;
        endcase
    endfunction

    function automatic logic [31:0] extract_load(input logic [31:0] rdata, input logic [1:0] size,
                                                 input logic uns, input logic [1:0] a);
        logic        [7:0]  b;
        logic        [15:0] h;
        logic signed [7:0]  bs;
        logic signed [15:0] hs;
        logic signed [31:0] sx;
        // Lane index is inverted because address byte 0 is the MSB lane.
        b  = rdata[{~a, 3'b000} +: 8];
        h  = a[1] ? rdata[15:0] : rdata[31:16];
        bs = signed'(b);
        hs = signed'(h);
        sx = 32'sd0;
        case (size)
            SZ_B: begin
                if (uns) extract_load = {24'd0, b};
                else begin sx = bs; extract_load = sx; end
            end
            SZ_H: begin
                if (uns) extract_load = {16'd0, h};
                else begin sx = hs; extract_load = sx; end
            end
            default: extract_load = rdata;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic        kill_q;
    logic [31:0] ld_q;

    logic        is_load, is_store, is_mem, uns, misalign, start;
    logic [1:0]  size;

    logic [4:0]  waddr_p1;
    logic        reg_we_p1, is_load_p1, uns_p1;
    logic [1:0]  size_p1, addr_lo_p1;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        uns      = 1'b0;
        size     = SZ_W;
        case (mem_aluop)
            ALU_LB_OP:  begin is_load  = 1'b1; size = SZ_B; end
            ALU_LBU_OP: begin is_load  = 1'b1; size = SZ_B; uns = 1'b1; end
            ALU_LH_OP:  begin is_load  = 1'b1; size = SZ_H; end
            ALU_LHU_OP: begin is_load  = 1'b1; size = SZ_H; uns = 1'b1; end
            ALU_LW_OP:  begin is_load  = 1'b1; size = SZ_W; end
            ALU_SB_OP:  begin is_store = 1'b1; size = SZ_B; end
            ALU_SH_OP:  begin is_store = 1'b1; size = SZ_H; end
            ALU_SW_OP:  begin is_store = 1'b1; size = SZ_W; end
            default: ;
        endcase
        is_mem   = is_load | is_store;
        misalign = ((size == SZ_H) &  mem_mem_addr[0]) |
                   ((size == SZ_W) & (|mem_mem_addr[1:0]));
    end

    // Next state and combinational outputs.
    always_comb begin
        state_d   = state_q;
        wb_waddr  = mem_waddr;
        wb_reg_we = 1'b0;
        wb_wdata  = 32'd0;
        stallreq  = 1'b0;
        adel      = 1'b0;
        ades      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (is_mem && misalign) begin
                    adel = is_load;
                    ades = is_store;
                end else if (is_mem && !flush) begin
                    stallreq = 1'b1;
                    state_d  = S_BUSY;
                end else begin
                    wb_reg_we = mem_reg_we;
                    wb_wdata  = mem_alu_res;
                end
            end
            S_BUSY: begin
                stallreq = 1'b1;
                wb_waddr = waddr_p1;
                // A flush arriving together with the ack kills the result too.
                if (bus.bus_ack)
                    state_d = (kill_q || flush) ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                wb_waddr  = waddr_p1;
                wb_reg_we = is_load_p1 & reg_we_p1;
                wb_wdata  = is_load_p1 ? ld_q : 32'd0;
                state_d   = (stall_mem && !flush) ? S_DONE : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign start = (state_q == S_IDLE) && (state_d == S_BUSY);

    // IDLE -> BUSY: launch the bus request; BUSY: wait for ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            kill_q        <= 1'b0;
            ld_q          <= 32'd0;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= 32'd0;
            bus.bus_sel   <= 4'd0;
            bus.bus_wdata <= 32'd0;
        end else begin
            state_q <= state_d;
            if (start) begin
                bus.bus_req   <= 1'b1;
                bus.bus_we    <= is_store;
                bus.bus_addr  <= {mem_mem_addr[31:2], 2'b00};
                bus.bus_sel   <= lane_sel(size, mem_mem_addr[1:0]);
                bus.bus_wdata <= store_data(size, mem_reg2_data);
                kill_q        <= 1'b0;
            end else if (state_q == S_BUSY) begin
                if (bus.bus_ack) begin
                    bus.bus_req <= 1'b0;
                    kill_q      <= 1'b0;
                    if (is_load_p1)
                        ld_q <= extract_load(bus.bus_rdata, size_p1, uns_p1, addr_lo_p1);
                end else if (flush) begin
                    kill_q <= 1'b1;
                end
            end
        end
    end

    // Extraction/writeback controls captured at launch (data path, no reset).
    always_ff @(posedge clk) begin
        if (start) begin
            waddr_p1   <= mem_waddr;
            reg_we_p1  <= mem_reg_we;
            is_load_p1 <= is_load;
            uns_p1     <= uns;
            size_p1    <= size;
            addr_lo_p1 <= mem_mem_addr[1:0];
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu
//
// Purpose: directed self-checking bench for mem_lsu. The bench plays both the
// EX/MEM register (instruction fields) and the data memory (rdata/ack).
// Inputs change on the falling edge; outputs are checked 1 time unit later.

module tb_mem_lsu;
    import mem_lsu_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               stall_mem, flush;
    logic [ALUOP_W-1:0] mem_aluop;
    logic [31:0]        mem_mem_addr, mem_reg2_data, mem_alu_res;
    logic [4:0]         mem_waddr;
    logic               mem_reg_we;
    logic [4:0]         wb_waddr;
    logic               wb_reg_we;
    logic [31:0]        wb_wdata;
    logic               stallreq, adel, ades;

    int n_cmp = 0;
    int n_bad = 0;

    mem_lsu_if bus_if ();

    mem_lsu dut (
        .clk          (clk),
        .rst          (rst),
        .stall_mem    (stall_mem),
        .flush        (flush),
        .mem_aluop    (mem_aluop),
        .mem_mem_addr (mem_mem_addr),
        .mem_reg2_data(mem_reg2_data),
        .mem_alu_res  (mem_alu_res),
        .mem_waddr    (mem_waddr),
        .mem_reg_we   (mem_reg_we),
        .wb_waddr     (wb_waddr),
        .wb_reg_we    (wb_reg_we),
        .wb_wdata     (wb_wdata),
        .stallreq     (stallreq),
        .adel         (adel),
        .ades         (ades),
        .bus          (bus_if.master)
    );

    always #5 clk = ~clk;

    task automatic set_op(input logic [ALUOP_W-1:0] op, input logic [31:0] addr,
                          input logic [31:0] reg2, input logic [31:0] alu,
                          input logic [4:0] waddr, input logic we);
        mem_aluop     = op;
        mem_mem_addr  = addr;
        mem_reg2_data = reg2;
        mem_alu_res   = alu;
        mem_waddr     = waddr;
        mem_reg_we    = we;
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        n_cmp++; if (bus_if.bus_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b want 0", bus_if.bus_req); end
        n_cmp++; if (bus_if.bus_we !== 1'b0) begin n_bad++; $display("FAIL rst_we: got %b want 0", bus_if.bus_we); end
        n_cmp++; if (bus_if.bus_addr !== 32'd0) begin n_bad++; $display("FAIL rst_addr: got %h want 0", bus_if.bus_addr); end
        n_cmp++; if (bus_if.bus_sel !== 4'd0) begin n_bad++; $display("FAIL rst_sel: got %b want 0000", bus_if.bus_sel); end
        n_cmp++; if (bus_if.bus_wdata !== 32'd0) begin n_bad++; $display("FAIL rst_wdata: got %h want 0", bus_if.bus_wdata); end
        n_cmp++; if (stallreq !== 1'b0) begin n_bad++; $display("FAIL rst_stallreq: got %b want 0", stallreq); end
        n_cmp++; if (wb_wdata !== 32'h0000_0055) begin n_bad++; $display("FAIL rst_pass: got %h want 00000055", wb_wdata); end
    endtask

    // LW at 0x100, ack two cycles after bus_req rises.
    task automatic test_lw_wait();
        @(negedge clk);
        set_op(ALU_LW_OP, 32'h100, 32'h0, 32'h0, 5'd5, 1'b1);
        #1;
        n_cmp++; if (stallreq !== 1'b1) begin n_bad++; $display("FAIL lw_stall_idle: got %b want 1", stallreq); end
        n_cmp++; if (wb_reg_we !== 1'b0) begin n_bad++; $display("FAIL lw_we_idle: got %b want 0", wb_reg_we); end
        @(negedge clk); #1;
        n_cmp++; if (bus_if.bus_req !== 1'b1) begin n_bad++; $display("FAIL lw_req: got %b want 1", bus_if.bus_req); end
        n_cmp++; if (bus_if.bus_sel !== 4'b1111) begin n_bad++; $display("FAIL lw_sel: got %b want 1111", bus_if.bus_sel); end
        n_cmp++; if (bus_if.bus_addr !== 32'h100) begin n_bad++; $display("FAIL lw_addr: got %h want 00000100", bus_if.bus_addr); end
        n_cmp++; if (bus_if.bus_we !== 1'b0) begin n_bad++; $display("FAIL lw_we: got %b want 0", bus_if.bus_we); end
        n_cmp++; if (stallreq !== 1'b1) begin n_bad++; $display("FAIL lw_stall_b1: got %b want 1", stallreq); end
        @(negedge clk);
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hDEAD_BEEF;
        #1;
        n_cmp++; if (stallreq !== 1'b1) begin n_bad++; $display("FAIL lw_stall_b2: got %b want 1", stallreq); end
        n_cmp++; if (bus_if.bus_req !== 1'b1) begin n_bad++; $display("FAIL lw_req_b2: got %b want 1", bus_if.bus_req); end
        @(negedge clk);
        bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0;
        #1;
        n_cmp++; if (stallreq !== 1'b0) begin n_bad++; $display("FAIL lw_stall_done: got %b want 0", stallreq); end
        n_cmp++; if (wb_wdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL lw_wdata: got %h want deadbeef", wb_wdata); end
        n_cmp++; if (wb_reg_we !== 1'b1) begin n_bad++; $display("FAIL lw_reg_we: got %b want 1", wb_reg_we); end
        n_cmp++; if (wb_waddr !== 5'd5) begin n_bad++; $display("FAIL lw_waddr: got %0d want 5", wb_waddr); end
        n_cmp++; if (bus_if.bus_req !== 1'b0) begin n_bad++; $display("FAIL lw_req_done: got %b want 0", bus_if.bus_req); end
        set_op(ALU_ADD_OP, 32'h0, 32'h0, 32'h0000_0777, 5'd1, 1'b1);
        @(negedge clk); #1;
        n_cmp++; if (wb_wdata !== 32'h0000_0777) begin n_bad++; $display("FAIL lw_after: got %h want 00000777", wb_wdata); end
    endtask

    // Single-wait-state loads over lane/extension combinations (back to back).
    task automatic test_lane_select();
        logic [ALUOP_W-1:0] ops[8]  = '{ALU_LB_OP, ALU_LBU_OP, ALU_LH_OP, ALU_LB_OP,
                                        ALU_LB_OP, ALU_LHU_OP, ALU_LH_OP, ALU_LHU_OP};
        logic [31:0] addrs[8] = '{32'h103, 32'h103, 32'h100, 32'h101,
                                  32'h100, 32'h102, 32'h100, 32'h100};
        logic [31:0] rdat[8]  = '{32'h112233F0, 32'h112233F0, 32'h112233F0, 32'h112233F0,
                                  32'h112233F0, 32'h112233F0, 32'h80010000, 32'h80010000};
        logic [3:0]  sels[8]  = '{4'b0001, 4'b0001, 4'b1100, 4'b0100,
                                  4'b1000, 4'b0011, 4'b1100, 4'b1100};
        logic [31:0] exps[8]  = '{32'hFFFFFFF0, 32'h000000F0, 32'h00001122, 32'h00000022,
                                  32'h00000011, 32'h000033F0, 32'hFFFF8001, 32'h00008001};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            set_op(ops[i], addrs[i], 32'h0, 32'h0, 5'd7, 1'b1);
            @(negedge clk); #1;
            n_cmp++; if (bus_if.bus_sel !== sels[i]) begin n_bad++; $display("FAIL ld%0d_sel: got %b want %b", i, bus_if.bus_sel, sels[i]); end
            bus_if.bus_ack = 1'b1; bus_if.bus_rdata = rdat[i];
            @(negedge clk);
            bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0;
            #1;
            n_cmp++; if (wb_wdata !== exps[i]) begin n_bad++; $display("FAIL ld%0d_data: got %h want %h", i, wb_wdata, exps[i]); end
            n_cmp++; if (wb_reg_we !== 1'b1) begin n_bad++; $display("FAIL ld%0d_we: got %b want 1", i, wb_reg_we); end
            set_op(ALU_ADD_OP, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
        end
    endtask

    task automatic test_store();
        logic [ALUOP_W-1:0] ops[3] = '{ALU_SH_OP, ALU_SB_OP, ALU_SW_OP};
        logic [31:0] addrs[3] = '{32'h202, 32'h201, 32'h204};
        logic [31:0] src[3]   = '{32'h0000ABCD, 32'h000000A5, 32'h01234567};
        logic [3:0]  sels[3]  = '{4'b0011, 4'b0100, 4'b1111};
        logic [31:0] wdat[3]  = '{32'hABCDABCD, 32'hA5A5A5A5, 32'h01234567};
        logic [31:0] wadr[3]  = '{32'h200, 32'h200, 32'h204};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_op(ops[i], addrs[i], src[i], 32'h0, 5'd3, 1'b1);
            #1;
            n_cmp++; if (ades !== 1'b0) begin n_bad++; $display("FAIL st%0d_ades: got %b want 0", i, ades); end
            @(negedge clk); #1;
            n_cmp++; if (bus_if.bus_we !== 1'b1) begin n_bad++; $display("FAIL st%0d_we: got %b want 1", i, bus_if.bus_we); end
            n_cmp++; if (bus_if.bus_sel !== sels[i]) begin n_bad++; $display("FAIL st%0d_sel: got %b want %b", i, bus_if.bus_sel, sels[i]); end
            n_cmp++; if (bus_if.bus_wdata !== wdat[i]) begin n_bad++; $display("FAIL st%0d_wdata: got %h want %h", i, bus_if.bus_wdata, wdat[i]); end
            n_cmp++; if (bus_if.bus_addr !== wadr[i]) begin n_bad++; $display("FAIL st%0d_addr: got %h want %h", i, bus_if.bus_addr, wadr[i]); end
            bus_if.bus_ack = 1'b1;
            @(negedge clk);
            bus_if.bus_ack = 1'b0;
            #1;
            n_cmp++; if (wb_reg_we !== 1'b0) begin n_bad++; $display("FAIL st%0d_reg_we: got %b want 0", i, wb_reg_we); end
            n_cmp++; if (stallreq !== 1'b0) begin n_bad++; $display("FAIL st%0d_stall: got %b want 0", i, stallreq); end
            set_op(ALU_ADD_OP, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
        end
    endtask

    task automatic test_misaligned();
        logic [ALUOP_W-1:0] ops[3] = '{ALU_LW_OP, ALU_SH_OP, ALU_LHU_OP};
        logic [31:0] addrs[3] = '{32'h102, 32'h201, 32'h101};
        logic        el[3]    = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_op(ops[i], addrs[i], 32'h0, 32'h0, 5'd4, 1'b1);
            #1;
            n_cmp++; if (adel !== el[i]) begin n_bad++; $display("FAIL mis%0d_adel: got %b want %b", i, adel, el[i]); end
            n_cmp++; if (ades !== !el[i]) begin n_bad++; $display("FAIL mis%0d_ades: got %b want %b", i, ades, !el[i]); end
            n_cmp++; if (stallreq !== 1'b0) begin n_bad++; $display("FAIL mis%0d_stall: got %b want 0", i, stallreq); end
            n_cmp++; if (wb_reg_we !== 1'b0) begin n_bad++; $display("FAIL mis%0d_we: got %b want 0", i, wb_reg_we); end
            @(negedge clk); #1;
            n_cmp++; if (bus_if.bus_req !== 1'b0) begin n_bad++; $display("FAIL mis%0d_req: got %b want 0", i, bus_if.bus_req); end
        end
        set_op(ALU_ADD_OP, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
    endtask

    task automatic test_passthrough();
        @(negedge clk);
        set_op(ALU_ADD_OP, 32'h0, 32'h0, 32'h1234_5678, 5'd9, 1'b1);
        bus_if.bus_ack = 1'b1;  // stray ack in IDLE must be ignored
        #1;
        n_cmp++; if (wb_wdata !== 32'h1234_5678) begin n_bad++; $display("FAIL pt_wdata: got %h want 12345678", wb_wdata); end
        n_cmp++; if (wb_reg_we !== 1'b1) begin n_bad++; $display("FAIL pt_we: got %b want 1", wb_reg_we); end
        n_cmp++; if (wb_waddr !== 5'd9) begin n_bad++; $display("FAIL pt_waddr: got %0d want 9", wb_waddr); end
        n_cmp++; if (stallreq !== 1'b0) begin n_bad++; $display("FAIL pt_stall: got %b want 0", stallreq); end
        @(negedge clk);
        bus_if.bus_ack = 1'b0;
        mem_alu_res = 32'h0BAD_F00D;
        #1;
        n_cmp++; if (wb_wdata !== 32'h0BAD_F00D) begin n_bad++; $display("FAIL pt_wdata2: got %h want 0badf00d", wb_wdata); end
        n_cmp++; if (bus_if.bus_req !== 1'b0) begin n_bad++; $display("FAIL pt_req: got %b want 0", bus_if.bus_req); end
    endtask

    // stall_mem in IDLE does not block a start; in DONE it holds the result.
    task automatic test_stall_mem();
        @(negedge clk);
        stall_mem = 1'b1;
        set_op(ALU_LW_OP, 32'h108, 32'h0, 32'h0, 5'd6, 1'b1);
        #1;
        n_cmp++; if (stallreq !== 1'b1) begin n_bad++; $display("FAIL sm_stall: got %b want 1", stallreq); end
        @(negedge clk); #1;
        n_cmp++; if (bus_if.bus_req !== 1'b1) begin n_bad++; $display("FAIL sm_req: got %b want 1", bus_if.bus_req); end
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hA1B2C3D4;
        @(negedge clk);
        bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0;
        set_op(ALU_ADD_OP, 32'h0, 32'h0, 32'h0000_0099, 5'd2, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            n_cmp++; if (wb_wdata !== 32'hA1B2C3D4) begin n_bad++; $display("FAIL sm_hold%0d: got %h want a1b2c3d4", i, wb_wdata); end
        end
        stall_mem = 1'b0;
        @(negedge clk); #1;
        n_cmp++; if (wb_wdata !== 32'h0000_0099) begin n_bad++; $display("FAIL sm_release: got %h want 00000099", wb_wdata); end
    endtask

    task automatic test_flush_busy();
        @(negedge clk);
        set_op(ALU_LW_OP, 32'h300, 32'h0, 32'h0, 5'd8, 1'b1);
        @(negedge clk);
        flush = 1'b1;
        #1;
        n_cmp++; if (stallreq !== 1'b1) begin n_bad++; $display("FAIL fl_stall: got %b want 1", stallreq); end
        @(negedge clk);
        flush = 1'b0;
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h5555_AAAA;
        #1;
        n_cmp++; if (bus_if.bus_req !== 1'b1) begin n_bad++; $display("FAIL fl_req: got %b want 1", bus_if.bus_req); end
        @(negedge clk);
        bus_if.bus_ack = 1'b0;
        set_op(ALU_ADD_OP, 32'h0, 32'h0, 32'hCAFE_0001, 5'd8, 1'b0);
        #1;
        n_cmp++; if (wb_wdata !== 32'hCAFE_0001) begin n_bad++; $display("FAIL fl_nodone: got %h want cafe0001", wb_wdata); end
        n_cmp++; if (wb_reg_we !== 1'b0) begin n_bad++; $display("FAIL fl_we: got %b want 0", wb_reg_we); end
        n_cmp++; if (bus_if.bus_req !== 1'b0) begin n_bad++; $display("FAIL fl_req_end: got %b want 0", bus_if.bus_req); end
    endtask

    task automatic test_reset_busy();
        @(negedge clk);
        set_op(ALU_LW_OP, 32'h400, 32'h0, 32'h0, 5'd10, 1'b1);
        @(negedge clk); #1;
        n_cmp++; if (bus_if.bus_req !== 1'b1) begin n_bad++; $display("FAIL rb_req: got %b want 1", bus_if.bus_req); end
        #1 rst = 1'b0;
        #1;
        n_cmp++; if (bus_if.bus_req !== 1'b0) begin n_bad++; $display("FAIL rb_req_drop: got %b want 0", bus_if.bus_req); end
        n_cmp++; if (bus_if.bus_sel !== 4'd0) begin n_bad++; $display("FAIL rb_sel: got %b want 0000", bus_if.bus_sel); end
        @(negedge clk);
        rst = 1'b1;
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h7777_7777;
        set_op(ALU_ADD_OP, 32'h0, 32'h0, 32'h0000_4242, 5'd1, 1'b1);
        @(negedge clk);
        bus_if.bus_ack = 1'b0;
        #1;
        n_cmp++; if (wb_wdata !== 32'h0000_4242) begin n_bad++; $display("FAIL rb_idle: got %h want 00004242", wb_wdata); end
        n_cmp++; if (stallreq !== 1'b0) begin n_bad++; $display("FAIL rb_stall: got %b want 0", stallreq); end
        n_cmp++; if (bus_if.bus_req !== 1'b0) begin n_bad++; $display("FAIL rb_req_late: got %b want 0", bus_if.bus_req); end
    endtask

    initial begin
        rst = 1'b0;
        stall_mem = 1'b0;
        flush = 1'b0;
        bus_if.bus_ack = 1'b0;
        bus_if.bus_rdata = 32'h0;
        set_op(ALU_ADD_OP, 32'h0, 32'h0, 32'h0000_0055, 5'd0, 1'b0);
        test_reset();
        @(negedge clk);
        rst = 1'b1;
        test_lw_wait();
        test_lane_select();
        test_store();
        test_misaligned();
        test_passthrough();
        test_stall_mem();
        test_flush_busy();
        test_reset_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
